alu_ctrl_mdu: RTL and testbench

ALU_CTRL_MDU -- requirements
Module: alu_ctrl_mdu

---
 rtl/alu_ctrl_mdu.sv | 191 +++++++++++++++++++
 tb/tb_alu_ctrl_mdu.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_mdu.sv
// -----------------------------------------------------------------------------
// alu_ctrl_mdu
//
// Decodes the ALU control code from the instruction class (aluOp) and the
// funct field or opcode (func). The code, the illegal flag and valid_out are
// registered. A multiply/divide launch handshake can optionally be built in.
//
// Compile-time option:
//   ALU_CTRL_MDU_EN - when defined, builds the IDLE/RUN/DONE sequencer and the
//                     counter that drive mdu_start, mdu_op, hilo_we and
//                     stall_out. When undefined, func 0x18-0x1B with aluOp=00
//                     decodes as illegal and the MDU outputs are tied to zero.
//
// Parameters:
//   CTRL_W      width of the ALU control code (>= 4); the code is zero-extended
//   MUL_CYCLES  busy cycles per multiply (>= 1)
//   DIV_CYCLES  busy cycles per divide (>= MUL_CYCLES)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   valid_in   aluOp/func carry an instruction this cycle
//   aluOp      00 R-type, 01 I-type, 10 memory add, 11 reserved
//   func       R-type funct field or I-type opcode
//   flush      kills the instruction in this stage (no acceptance, no launch)
//   out        registered ALU control code
//   valid_out  out holds an instruction accepted in the previous cycle
//   illegal    registered; the accepted instruction did not decode
//   stall_out  upstream must hold; input is not accepted this cycle
//   mdu_start  one-cycle pulse launching the multiply/divide unit
//   mdu_op     00 mult, 01 multu, 10 div, 11 divu; held while busy
//   hilo_we    one-cycle HI/LO write-enable pulse at completion
// -----------------------------------------------------------------------------
module alu_ctrl_mdu #(
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [1:0]        aluOp,
  input  logic [5:0]        func,
  input  logic              flush,
  output logic [CTRL_W-1:0] out,
  output logic              valid_out,
  output logic              illegal,
  output logic              stall_out,
  output logic              mdu_start,
  output logic [1:0]        mdu_op,
  output logic              hilo_we
);

  logic [3:0]        code_d;
  logic              illegal_d;
  logic              is_mdu_d;
  logic              accept;
  logic [CTRL_W-1:0] out_q;
  logic              illegal_q;
  logic              valid_q;

  // Combinational decode. Every path starts from a clean default so a
  // previous code can never leak into an unlisted encoding.
  always_comb begin
    code_d    = 4'b0000;
    illegal_d = 1'b0;
    is_mdu_d  = 1'b0;
    case (aluOp)
      2'b00: begin
        case (func)
          6'h20: code_d = 4'b0000;
          6'h22: code_d = 4'b0001;
          6'h24: code_d = 4'b0010;
          6'h27: code_d = 4'b0011;
          6'h25: code_d = 4'b0100;
          6'h2A: code_d = 4'b0101;
          6'h18, 6'h19, 6'h1A, 6'h1B: begin
`ifdef ALU_CTRL_MDU_EN
            code_d   = {2'b10, func[1:0]};
            is_mdu_d = 1'b1;
`else
            illegal_d = 1'b1;
`endif
          end
          default: illegal_d = 1'b1;
        endcase
      end
      2'b01: begin
        case (func)
          6'h08:   code_d = 4'b0000;
          6'h09:   code_d = 4'b0001;
          6'h0C:   code_d = 4'b0010;
          6'h0D:   code_d = 4'b0100;
          6'h0A:   code_d = 4'b0101;
          6'h04:   code_d = 4'b0110;
          6'h05:   code_d = 4'b0111;
          6'h01:   code_d = 4'b1100;
          default: illegal_d = 1'b1;
        endcase
      end
      2'b10:   code_d    = 4'b0000;
      default: illegal_d = 1'b1;
    endcase
  end

  assign accept = valid_in & ~stall_out & ~flush;

  // Decode result registers: out/illegal only move on acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q     <= '0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= accept;
      if (accept) begin
        out_q     <= CTRL_W'(code_d);
        illegal_q <= illegal_d;
      end
    end
  end

  assign out       = out_q;
  assign illegal   = illegal_q;
  assign valid_out = valid_q;

`ifdef ALU_CTRL_MDU_EN
  localparam int CNT_W = $clog2(DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mdu_start_q;
  logic [1:0]       mdu_op_q;
  logic             hilo_we_q;

  // RUN lasts N cycles (counter N-1 down to 0), DONE one more, so the unit is
  // occupied N+1 cycles from the mdu_start cycle through the hilo_we cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mdu_start_q <= 1'b0;
      mdu_op_q    <= 2'b00;
      hilo_we_q   <= 1'b0;
    end else begin
      mdu_start_q <= 1'b0;
      hilo_we_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept && is_mdu_d) begin
            mdu_start_q <= 1'b1;
            mdu_op_q    <= func[1:0];
            // func[1] separates div/divu from mult/multu
            cnt_q       <= func[1] ? DIV_LOAD : MUL_LOAD;
            state_q     <= S_RUN;
          end
        end
        S_RUN: begin
          if (cnt_q == '0) begin
            state_q   <= S_DONE;
            hilo_we_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall_out = (state_q != S_IDLE);
  assign mdu_start = mdu_start_q;
  assign mdu_op    = mdu_op_q;
  assign hilo_we   = hilo_we_q;
`else
  assign stall_out = 1'b0;
  assign mdu_start = 1'b0;
  assign mdu_op    = 2'b00;
  assign hilo_we   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// -----------------------------------------------------------------------------
// Testbench for alu_ctrl_mdu: table of decode vectors, hand-written MDU
// sequences (only when ALU_CTRL_MDU_EN is defined) and a randomized run
// checked against an occupancy-count reference model.
// -----------------------------------------------------------------------------
module tb_alu_ctrl_mdu;

  localparam int CTRL_W     = 4;
  localparam int MUL_CYCLES = 4;
  localparam int DIV_CYCLES = 32;
`ifdef ALU_CTRL_MDU_EN
  localparam bit HAS_MDU = 1'b1;
`else
  localparam bit HAS_MDU = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_in;
  logic [1:0]        aluOp;
  logic [5:0]        func;
  logic              flush;
  logic [CTRL_W-1:0] out;
  logic              valid_out;
  logic              illegal;
  logic              stall_out;
  logic              mdu_start;
  logic [1:0]        mdu_op;
  logic              hilo_we;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_ctrl_mdu #(
    .CTRL_W     (CTRL_W),
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .aluOp     (aluOp),
    .func      (func),
    .flush     (flush),
    .out       (out),
    .valid_out (valid_out),
    .illegal   (illegal),
    .stall_out (stall_out),
    .mdu_start (mdu_start),
    .mdu_op    (mdu_op),
    .hilo_we   (hilo_we)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference decode: a lookup table of legal encodings -------
  typedef struct {
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] code;
  } dec_ent_t;
  dec_ent_t dec_tab[$];

  task automatic add_dec(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] code);
    dec_ent_t e;
    e.op = op; e.fn = fn; e.code = code;
    dec_tab.push_back(e);
  endtask

  function automatic void ref_decode(input logic [1:0] op, input logic [5:0] fn,
                                     output logic [3:0] code, output logic ill);
    code = 4'h0;
    ill  = 1'b1;
    if (op == 2'b10) begin
      ill = 1'b0;
      return;
    end
    foreach (dec_tab[i]) begin
      if (dec_tab[i].op == op && dec_tab[i].fn == fn) begin
        code = dec_tab[i].code;
        ill  = 1'b0;
      end
    end
  endfunction

  // ---------------- decode vector table -----------------------------------
  typedef struct {
    logic       vld;
    logic [1:0] op;
    logic [5:0] fn;
    logic       fl;
    logic [3:0] e_out;
    logic       e_ill;
    logic       e_vld;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic vld, input logic [1:0] op, input logic [5:0] fn, input logic fl,
                         input logic [3:0] e_out, input logic e_ill, input logic e_vld);
    vec_t v;
    v.vld = vld; v.op = op; v.fn = fn; v.fl = fl;
    v.e_out = e_out; v.e_ill = e_ill; v.e_vld = e_vld;
    vecs.push_back(v);
  endtask

  // ---------------- behavioural model state --------------------------------
  int         m_busy;     // remaining cycles of MDU occupancy (stall high while > 0)
  logic [3:0] m_out;
  logic       m_ill;
  logic       m_vld;
  logic       m_start;
  logic [1:0] m_op;
  logic       m_hilo;

  logic [5:0] funcs [18] = '{6'h20, 6'h22, 6'h24, 6'h27, 6'h25, 6'h2A, 6'h18, 6'h19, 6'h1A,
                             6'h1B, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0A, 6'h04, 6'h05, 6'h01};

  initial begin
    // Legal encodings
    add_dec(2'b00, 6'h20, 4'h0); add_dec(2'b00, 6'h22, 4'h1); add_dec(2'b00, 6'h24, 4'h2);
    add_dec(2'b00, 6'h27, 4'h3); add_dec(2'b00, 6'h25, 4'h4); add_dec(2'b00, 6'h2A, 4'h5);
    add_dec(2'b01, 6'h08, 4'h0); add_dec(2'b01, 6'h09, 4'h1); add_dec(2'b01, 6'h0C, 4'h2);
    add_dec(2'b01, 6'h0D, 4'h4); add_dec(2'b01, 6'h0A, 4'h5); add_dec(2'b01, 6'h04, 4'h6);
    add_dec(2'b01, 6'h05, 4'h7); add_dec(2'b01, 6'h01, 4'hC);
`ifdef ALU_CTRL_MDU_EN
    add_dec(2'b00, 6'h18, 4'h8); add_dec(2'b00, 6'h19, 4'h9);
    add_dec(2'b00, 6'h1A, 4'hA); add_dec(2'b00, 6'h1B, 4'hB);
`endif

    // Table of single-cycle decode vectors (applied back to back from idle)
    add_vec(1'b1, 2'b00, 6'h2A, 1'b0, 4'h5, 1'b0, 1'b1);
    add_vec(1'b1, 2'b01, 6'h3F, 1'b0, 4'h0, 1'b1, 1'b1);
    add_vec(1'b1, 2'b11, 6'h20, 1'b0, 4'h0, 1'b1, 1'b1);
    add_vec(1'b1, 2'b00, 6'h22, 1'b0, 4'h1, 1'b0, 1'b1);
    add_vec(1'b0, 2'b00, 6'h24, 1'b0, 4'h1, 1'b0, 1'b0); // no valid: hold
    add_vec(1'b1, 2'b01, 6'h01, 1'b0, 4'hC, 1'b0, 1'b1);
    add_vec(1'b1, 2'b00, 6'h24, 1'b1, 4'hC, 1'b0, 1'b0); // flushed: hold
    add_vec(1'b1, 2'b10, 6'h3F, 1'b0, 4'h0, 1'b0, 1'b1);
    add_vec(1'b1, 2'b01, 6'h0D, 1'b0, 4'h4, 1'b0, 1'b1);
    add_vec(1'b1, 2'b00, 6'h3F, 1'b0, 4'h0, 1'b1, 1'b1);
    add_vec(1'b1, 2'b01, 6'h05, 1'b0, 4'h7, 1'b0, 1'b1);
    add_vec(1'b1, 2'b00, 6'h27, 1'b0, 4'h3, 1'b0, 1'b1);
    add_vec(1'b1, 2'b00, 6'h25, 1'b0, 4'h4, 1'b0, 1'b1);
`ifndef ALU_CTRL_MDU_EN
    add_vec(1'b1, 2'b00, 6'h19, 1'b0, 4'h0, 1'b1, 1'b1); // MDU funcs illegal in this build
    add_vec(1'b1, 2'b00, 6'h1A, 1'b0, 4'h0, 1'b1, 1'b1);
`endif

    // ---------------- reset state ----------------
    reset = 1'b1; valid_in = 1'b0; aluOp = 2'b00; func = 6'h00; flush = 1'b0;
    tick(); tick();
    chk("rst_out",       32'(out),       32'h0);
    chk("rst_valid_out", 32'(valid_out), 32'h0);
    chk("rst_illegal",   32'(illegal),   32'h0);
    chk("rst_stall",     32'(stall_out), 32'h0);
    chk("rst_mdu_start", 32'(mdu_start), 32'h0);
    chk("rst_mdu_op",    32'(mdu_op),    32'h0);
    chk("rst_hilo_we",   32'(hilo_we),   32'h0);
    reset = 1'b0;

    // ---------------- table-driven decode ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      valid_in = vecs[i].vld; aluOp = vecs[i].op; func = vecs[i].fn; flush = vecs[i].fl;
      tick();
      chk($sformatf("vec%0d_out", i),       32'(out),       32'(vecs[i].e_out));
      chk($sformatf("vec%0d_illegal", i),   32'(illegal),   32'(vecs[i].e_ill));
      chk($sformatf("vec%0d_valid_out", i), 32'(valid_out), 32'(vecs[i].e_vld));
      chk($sformatf("vec%0d_stall", i),     32'(stall_out), 32'h0);
      chk($sformatf("vec%0d_mdu_start", i), 32'(mdu_start), 32'h0);
    end
    valid_in = 1'b0; flush = 1'b0;
    tick();

`ifdef ALU_CTRL_MDU_EN
    // ---------------- divide timing: accept at T, occupancy T+1..T+33 -------
    valid_in = 1'b1; aluOp = 2'b00; func = 6'h1A;
    chk("div_idle_stall", 32'(stall_out), 32'h0);
    tick(); // T+1
    chk("div_start",     32'(mdu_start), 32'h1);
    chk("div_op",        32'(mdu_op),    32'h2);
    chk("div_stall_t1",  32'(stall_out), 32'h1);
    chk("div_out",       32'(out),       32'hA);
    chk("div_valid_out", 32'(valid_out), 32'h1);
    func = 6'h20; // held add instruction
    for (int k = 2; k <= DIV_CYCLES + 1; k++) begin
      tick();
      chk($sformatf("div_stall_t%0d", k), 32'(stall_out), 32'h1);
      chk($sformatf("div_hilo_t%0d", k),  32'(hilo_we),   32'(k == DIV_CYCLES + 1));
      chk($sformatf("div_vout_t%0d", k),  32'(valid_out), 32'h0);
      chk($sformatf("div_op_t%0d", k),    32'(mdu_op),    32'h2);
    end
    tick(); // first idle cycle: held instruction accepted at its end
    chk("div_stall_end",   32'(stall_out), 32'h0);
    chk("div_hilo_end",    32'(hilo_we),   32'h0);
    chk("div_held_notyet", 32'(valid_out), 32'h0);
    tick();
    chk("div_held_valid",  32'(valid_out), 32'h1);
    chk("div_held_out",    32'(out),       32'h0);
    chk("div_held_ill",    32'(illegal),   32'h0);
    valid_in = 1'b0;

    // ---------------- multu occupancy count ----------------
    begin
      int busy_cnt;
      int hilo_at;
      valid_in = 1'b1; func = 6'h19;
      tick();
      valid_in = 1'b0;
      busy_cnt = 0; hilo_at = -1;
      for (int k = 0; k < 12; k++) begin
        if (stall_out) busy_cnt++;
        if (hilo_we) hilo_at = k;
        tick();
      end
      chk("mulu_occupancy", 32'(busy_cnt), 32'(MUL_CYCLES + 1));
      chk("mulu_hilo_pos",  32'(hilo_at),  32'(MUL_CYCLES));
    end

    // ---------------- flush blocks launch ----------------
    valid_in = 1'b1; aluOp = 2'b00; func = 6'h18; flush = 1'b1;
    tick();
    chk("flush_start",     32'(mdu_start), 32'h0);
    chk("flush_valid_out", 32'(valid_out), 32'h0);
    chk("flush_stall",     32'(stall_out), 32'h0);
    valid_in = 1'b0; flush = 1'b0;
    tick();
    chk("flush_stall2",    32'(stall_out), 32'h0);

    // ---------------- reset 5 cycles into a divide ----------------
    begin
      logic seen;
      valid_in = 1'b1; func = 6'h1B;
      tick();
      valid_in = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      chk("rstdiv_busy", 32'(stall_out), 32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rstdiv_out",   32'(out),       32'h0);
      chk("rstdiv_vout",  32'(valid_out), 32'h0);
      chk("rstdiv_ill",   32'(illegal),   32'h0);
      chk("rstdiv_start", 32'(mdu_start), 32'h0);
      chk("rstdiv_op",    32'(mdu_op),    32'h0);
      chk("rstdiv_stall", 32'(stall_out), 32'h0);
      seen = 1'b0;
      for (int k = 0; k < DIV_CYCLES + 8; k++) begin
        seen = seen | hilo_we | stall_out;
        tick();
      end
      chk("rstdiv_no_hilo_or_stall", 32'(seen), 32'h0);
    end
`endif

    // ---------------- randomized run against the occupancy model -----------
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic       acc;
      logic [3:0] d_code;
      logic       d_ill;
      reset    = (cyc == 0) || ($urandom_range(299) == 0);
      valid_in = ($urandom_range(3) != 0);
      flush    = ($urandom_range(9) == 0);
      aluOp    = ($urandom_range(5) == 0) ? 2'($urandom) : 2'($urandom_range(1));
      func     = ($urandom_range(4) == 0) ? 6'($urandom) : funcs[$urandom_range(17)];
      if (cyc > 0) chk($sformatf("rnd%0d_stall", cyc), 32'(stall_out), 32'(m_busy > 0));
      tick();
      if (reset) begin
        m_busy = 0; m_out = 4'h0; m_ill = 1'b0; m_vld = 1'b0; m_start = 1'b0; m_op = 2'b00;
      end else begin
        acc = valid_in && !flush && (m_busy == 0);
        m_vld = acc;
        if (acc) begin
          ref_decode(aluOp, func, d_code, d_ill);
          m_out = d_code; m_ill = d_ill;
        end
        m_start = 1'b0;
        if (acc && HAS_MDU && aluOp == 2'b00 && func >= 6'h18 && func <= 6'h1B) begin
          m_start = 1'b1;
          m_op    = func[1:0];
          m_busy  = (func[1] ? DIV_CYCLES : MUL_CYCLES) + 1;
        end else if (m_busy > 0) begin
          m_busy--;
        end
      end
      m_hilo = (m_busy == 1);
      chk($sformatf("rnd%0d_out", cyc),       32'(out),       32'(m_out));
      chk($sformatf("rnd%0d_illegal", cyc),   32'(illegal),   32'(m_ill));
      chk($sformatf("rnd%0d_valid_out", cyc), 32'(valid_out), 32'(m_vld));
      chk($sformatf("rnd%0d_mdu_start", cyc), 32'(mdu_start), 32'(m_start));
      chk($sformatf("rnd%0d_mdu_op", cyc),    32'(mdu_op),    32'(m_op));
      chk($sformatf("rnd%0d_hilo_we", cyc),   32'(hilo_we),   32'(m_hilo));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
